// File: rtl/dma_rr_arbiter_if.sv
// Bundle of the client-side and bridge-side signals of the DMA round-robin
// arbiter.
//   master : arbiter view. It takes the client strobes, addresses and write
//            data plus the bridge ack/read data. It drives the client
//            ack/err/read data, the bridge request bus and the timeout count.
//   slave  : environment view (clients plus bridge), with every direction
//            flipped.
// Client i owns caddr[32i+31:32i] and cwdata[16i+15:16i].
interface dma_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    creq;
  logic [N-1:0]    cwr;
  logic [32*N-1:0] caddr;
  logic [16*N-1:0] cwdata;
  logic [N-1:0]    cack;
  logic [15:0]     crdata;
  logic [N-1:0]    cerr;
  logic            memreq;
  logic            memwr;
  logic [31:0]     memaddr;
  logic [15:0]     memwdata;
  logic            memack;
  logic [15:0]     memrdata;
  logic [7:0]      tmocnt;

  modport master (
    input  creq, cwr, caddr, cwdata, memack, memrdata,
    output cack, crdata, cerr, memreq, memwr, memaddr, memwdata, tmocnt
  );

  modport slave (
    output creq, cwr, caddr, cwdata, memack, memrdata,
    input  cack, crdata, cerr, memreq, memwr, memaddr, memwdata, tmocnt
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter that shares the single 16-bit peripheral memory port of
// the AXI DMA bridge between N single-word DMA clients. It keeps one bridge
// transaction outstanding at a time, returns the ack and read data to the
// issuer, and forces completion (with cerr) if the bridge does not answer
// within TMO cycles.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : dma_rr_arbiter_if.master
//          (client creq/cwr/caddr/cwdata in, cack/cerr/crdata out;
//           bridge memreq/memwr/memaddr/memwdata out, memack/memrdata in;
//           tmocnt out)
module dma_rr_arbiter #(
  parameter int N   = 4,
  parameter int TMO = 1023
) (
  input  logic                clk,
  input  logic                rst,
  dma_rr_arbiter_if.master    bus
);

  localparam int             LW    = $clog2(N);
  localparam logic [9:0]     TMO_W = 10'(TMO);
  localparam logic [N-1:0]   ONE   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   gnt_q, gnt_d;
  logic [9:0]      cnt_q, cnt_d;
  logic            memreq_q, memreq_d;
  logic            memwr_q, memwr_d;
  logic [31:0]     memaddr_q, memaddr_d;
  logic [15:0]     memwdata_q, memwdata_d;
  logic [N-1:0]    cack_q, cack_d;
  logic [N-1:0]    cerr_q, cerr_d;
  logic [15:0]     crdata_q, crdata_d;
  logic [7:0]      tmocnt_q, tmocnt_d;

  logic [N-1:0]    elig;
  logic            found;
  logic [LW-1:0]   sel;
  logic [LW-1:0]   idx;
  logic [31:0]     sel_addr;
  logic [15:0]     sel_wdata;
  logic            sel_wr;
  logic [N-1:0]    gnt_oh;
  logic            tmo_hit;

  // A strobe may win in the cycle it arrives; the scan starts just past the
  // last client served, so the most recent winner has the lowest priority.
  always_comb begin
    elig  = pend_q | bus.creq;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last_q) + k) % N);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == LW'(i)) begin
        sel_addr  = bus.caddr[32*i +: 32];
        sel_wdata = bus.cwdata[16*i +: 16];
        sel_wr    = bus.cwr[i];
      end
    end
  end

  assign gnt_oh  = ONE << gnt_q;
  assign tmo_hit = (cnt_q == TMO_W);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = WAIT;
      WAIT:    if (bus.memack || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    // The in-flight client cannot re-post until its own ack.
    pend_d     = pend_q | (bus.creq & ((state_q == WAIT) ? ~gnt_oh : {N{1'b1}}));
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    memreq_d   = 1'b0;
    memwr_d    = memwr_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    cack_d     = '0;
    cerr_d     = '0;
    crdata_d   = crdata_q;
    tmocnt_d   = tmocnt_q;
    case (state_q)
      IDLE: begin
        // A memack seen here is a late reply to a timed-out request; ignored.
        if (found) begin
          gnt_d       = sel;
          memaddr_d   = sel_addr;
          memwdata_d  = sel_wdata;
          memwr_d     = sel_wr;
          memreq_d    = 1'b1;
          pend_d[sel] = 1'b0;
          cnt_d       = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 10'd1;
        // A real ack beats a timeout landing in the same cycle.
        if (bus.memack) begin
          cack_d   = gnt_oh;
          crdata_d = bus.memrdata;
          last_d   = gnt_q;
        end else if (tmo_hit) begin
          cack_d   = gnt_oh;
          cerr_d   = gnt_oh;
          crdata_d = '0;
          last_d   = gnt_q;
          if (tmocnt_q != 8'hFF) tmocnt_d = tmocnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      last_q     <= LW'(N - 1);
      gnt_q      <= '0;
      cnt_q      <= '0;
      memreq_q   <= 1'b0;
      memwr_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      cack_q     <= '0;
      cerr_q     <= '0;
      crdata_q   <= '0;
      tmocnt_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      memreq_q   <= memreq_d;
      memwr_q    <= memwr_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      cack_q     <= cack_d;
      cerr_q     <= cerr_d;
      crdata_q   <= crdata_d;
      tmocnt_q   <= tmocnt_d;
    end
  end

  assign bus.memreq   = memreq_q;
  assign bus.memwr    = memwr_q;
  assign bus.memaddr  = memaddr_q;
  assign bus.memwdata = memwdata_q;
  assign bus.cack     = cack_q;
  assign bus.cerr     = cerr_q;
  assign bus.crdata   = crdata_q;
  assign bus.tmocnt   = tmocnt_q;

endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Directed bench for dma_rr_arbiter (N=4, TMO=16) with scoreboard queues of
// expected bridge grants and client completions, each tagged with the cycle
// in which it must appear.
module tb_dma_rr_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dma_rr_arbiter_if #(.N(N)) bus();

  dma_rr_arbiter #(.N(N), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0]  ca  [N];
  logic [15:0]  cwd [N];
  logic [N-1:0] cw;

  always_comb begin
    bus.caddr  = '0;
    bus.cwdata = '0;
    for (int i = 0; i < N; i++) begin
      bus.caddr[32*i +: 32]  = ca[i];
      bus.cwdata[16*i +: 16] = cwd[i];
    end
  end
  assign bus.cwr = cw;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [15:0] b;
    logic        c;
  } ent_t;

  ent_t gq[$];
  ent_t cq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_grant(input int due, input int c);
    ent_t e;
    e.due = due; e.a = ca[c]; e.b = cwd[c]; e.c = cw[c];
    gq.push_back(e);
  endtask

  task automatic exp_done(input int due, input int c, input logic [15:0] rd, input logic err);
    ent_t e;
    e.due = due; e.a = 32'(c); e.b = rd; e.c = err;
    cq.push_back(e);
  endtask

  // Advance one clock and check bridge request and client completion.
  task automatic tick();
    ent_t        e;
    logic [31:0] oh;
    @(posedge clk);
    #1;
    cyc++;
    if (gq.size() > 0 && gq[0].due == cyc) begin
      e = gq.pop_front();
      chk("memreq", 32'(bus.memreq), 32'd1);
      chk("memaddr", bus.memaddr, e.a);
      chk("memwdata", 32'(bus.memwdata), 32'(e.b));
      chk("memwr", 32'(bus.memwr), 32'(e.c));
    end else begin
      chk("memreq_idle", 32'(bus.memreq), 32'd0);
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      e  = cq.pop_front();
      oh = 32'd1 << e.a;
      chk("cack", 32'(bus.cack), oh);
      chk("cerr", 32'(bus.cerr), e.c ? oh : 32'd0);
      chk("crdata", 32'(bus.crdata), 32'(e.b));
    end else begin
      chk("cack_idle", 32'(bus.cack), 32'd0);
      chk("cerr_idle", 32'(bus.cerr), 32'd0);
    end
  endtask

  // Issue to client c (creq, if any, already driven for this cycle), hold
  // for w WAIT cycles checking the bus is stable, then ack with rd.
  task automatic serve(input int c, input int w, input logic [15:0] rd);
    exp_grant(cyc + 1, c);
    tick();
    bus.creq = '0;
    repeat (w) begin
      tick();
      chk("hold_addr", bus.memaddr, ca[c]);
      chk("hold_wdata", 32'(bus.memwdata), 32'(cwd[c]));
      chk("hold_wr", 32'(bus.memwr), 32'(cw[c]));
    end
    bus.memack   = 1'b1;
    bus.memrdata = rd;
    exp_done(cyc + 1, c, rd, 1'b0);
    tick();
    bus.memack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cack"}, 32'(bus.cack), 32'd0);
    chk({tag, "_cerr"}, 32'(bus.cerr), 32'd0);
    chk({tag, "_memreq"}, 32'(bus.memreq), 32'd0);
    chk({tag, "_memwr"}, 32'(bus.memwr), 32'd0);
    chk({tag, "_memaddr"}, bus.memaddr, 32'd0);
    chk({tag, "_memwdata"}, 32'(bus.memwdata), 32'd0);
    chk({tag, "_crdata"}, 32'(bus.crdata), 32'd0);
    chk({tag, "_tmocnt"}, 32'(bus.tmocnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required end of test", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.creq     = '0;
    bus.memack   = 1'b0;
    bus.memrdata = '0;
    cw           = '0;
    for (int i = 0; i < N; i++) begin
      ca[i]  = 32'h1000 * (i + 1);
      cwd[i] = 16'h00A0 + 16'(i);
    end

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Single read, ack in the third WAIT cycle
    ca[0]    = 32'h100;
    bus.creq = 4'b0001;
    serve(0, 2, 16'hBEEF);
    repeat (2) tick();

    // Simultaneous strobes straight after reset: order 0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.creq = 4'b1111;
    for (int i = 0; i < N; i++) serve(i, 1, 16'h5000 + 16'(i));
    repeat (3) tick();
    chk("tmocnt_after_burst", 32'(bus.tmocnt), 32'd0);

    // Write path from client 1
    cw[1]    = 1'b1;
    ca[1]    = 32'h2004;
    cwd[1]   = 16'h1234;
    bus.creq = 4'b0010;
    serve(1, 3, 16'h7777);
    cw[1] = 1'b0;
    repeat (2) tick();

    // Round robin: 0,2,3 strobe together after client 1 was served last;
    // client 2 re-requests right after its ack: order 2,3,0,2
    bus.creq = 4'b1101;
    serve(2, 0, 16'h2222);
    bus.creq = 4'b0100;
    serve(3, 0, 16'h3333);
    serve(0, 0, 16'h0A0A);
    serve(2, 0, 16'h2B2B);
    repeat (3) tick();

    // Timeout on client 3; client 0 strobes mid-wait
    bus.creq = 4'b1000;
    exp_grant(cyc + 1, 3);
    tick();
    bus.creq = '0;
    m = cyc;
    for (int k = 1; k <= TMO; k++) begin
      bus.creq = (k == 5) ? 4'b0001 : 4'b0000;
      tick();
      chk("tmo_hold_addr", bus.memaddr, ca[3]);
    end
    bus.creq = '0;
    exp_done(m + TMO + 1, 3, 16'h0000, 1'b1);
    exp_grant(m + TMO + 2, 0);
    tick();
    chk("tmo_latency", 32'(cyc - m), 32'(TMO + 1));
    chk("tmocnt_one", 32'(bus.tmocnt), 32'd1);
    // Late reply arrives in IDLE: no cack, crdata untouched
    bus.memack   = 1'b1;
    bus.memrdata = 16'hDEAD;
    tick();
    bus.memack = 1'b0;
    chk("stray_crdata", 32'(bus.crdata), 32'd0);
    tick();
    bus.memack   = 1'b1;
    bus.memrdata = 16'h0C0C;
    exp_done(cyc + 1, 0, 16'h0C0C, 1'b0);
    tick();
    bus.memack = 1'b0;

    // memack exactly when the counter reaches TMO: ack wins
    bus.creq = 4'b0010;
    serve(1, TMO, 16'h1616);
    chk("tmocnt_ack_wins", 32'(bus.tmocnt), 32'd1);
    tick();

    // Reset two cycles after memreq
    bus.creq = 4'b0100;
    exp_grant(cyc + 1, 2);
    tick();
    bus.creq = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    bus.memack = 1'b1;
    tick();
    bus.memack = 1'b0;
    tick();
    bus.creq = 4'b0101;
    serve(0, 1, 16'h4040);
    serve(2, 1, 16'h4242);
    repeat (3) tick();

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("done_queue_empty", 32'(cq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_rr_arbiter.md
Name: dma_rr_arbiter

Overview:
- Round-robin arbiter that lets N peripheral DMA clients (RL, RK, TM disk/tape controllers) share the single 16-bit peripheral memory port of the AXI DMA bridge.
- Each client posts single-word read/write strobes. The arbiter serialises them to one outstanding transaction, routes the ack and read data back to the issuer, and recovers from a hung bridge with a timeout.

Parameters:
- N, 4, number of clients (2..8).
- TMO, 1023, cycles to wait for memack before a forced completion (10-bit counter, 1..1023).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- creq  in  N  per-client one-cycle request strobe.
- cwr  in  N  per-client write flag; held stable from strobe until that client's ack.
- caddr  in  32*N  client i byte address in bits [32i+31:32i]; held until ack.
- cwdata  in  16*N  client i write data in bits [16i+15:16i]; held until ack.
- cack  out  N  one-cycle completion pulse to the issuing client.
- crdata  out  16  read data, shared; valid in the cycle cack is high.
- cerr  out  N  one-cycle pulse coincident with cack when completion was forced by timeout.
- memreq  out  1  one-cycle request strobe to the bridge.
- memwr  out  1  write flag, held until memack.
- memaddr  out  32  address, held until memack.
- memwdata  out  16  write data, held until memack.
- memack  in  1  one-cycle completion from the bridge; read data valid the same cycle.
- memrdata  in  16  bridge read data.
- tmocnt  out  8  saturating count of timeouts, for debug register readout.

Behaviour:
- Reset (async): state=IDLE; pend=0; last=N-1, so client 0 wins first.
- Outputs at reset: cack, cerr, memreq, memwr, memaddr, memwdata, crdata and tmocnt are all 0.
- pend[i] is set by creq[i] and cleared when the transaction for client i completes.
- A creq[i] arriving while pend[i] is already set, or while i is in flight, is ignored. Clients must not do this; the bench flags it as a protocol warning, not an error.
- Eligible set E = pend | creq, so a strobe can win in the same cycle it arrives.
- IDLE:
  - If E != 0, choose g = first set bit of E scanning last+1, last+2, … modulo N.
  - Register memaddr, memwdata and memwr from client g; pulse memreq for one cycle; clear pend[g]; load counter=0; go to WAIT.
  - Latency: creq high in cycle c gives memreq high in cycle c+1.
- WAIT:
  - The counter increments each cycle.
  - On memack: cack[g]=1 next cycle, crdata=memrdata registered (written for writes too), last=g, go to IDLE.
  - On counter==TMO with no memack: cack[g]=1 and cerr[g]=1 next cycle, crdata=0, tmocnt+=1 saturating at 255, last=g, go to IDLE.
  - memack and the timeout in the same cycle: memack wins, no cerr.
- A memack seen in IDLE is stray (late reply after a timeout) and is ignored. No cack is generated and crdata is unchanged.
- memreq is strictly one cycle and never reasserted while in WAIT. At most one bridge transaction is outstanding.
- Throughput: memack in cycle d gives cack in cycle d+1. The next memreq comes no earlier than d+2, i.e. a minimum of 3 cycles per transaction.
- New creq strobes arriving during WAIT are latched into pend and do not disturb the in-flight transaction.
- Fairness: a client continuously re-requesting waits at most N-1 other transactions before being served.
- Reset asserted mid-WAIT drops the transaction and all pend bits. Clients must restart.

Test Plan:
- Single read: creq=0001, caddr0=0x100, memack in the 3rd WAIT cycle with memrdata=0xBEEF.
  - Required: memreq exactly one cycle, in the cycle after creq, with memaddr=0x100, memwr=0.
  - Required: cack=0001 and crdata=0xBEEF one cycle after memack.
- Simultaneous strobes: creq=1111 at reset, each transaction acked after 1 cycle.
  - Required: grant order 0,1,2,3; pend bits drain; exactly four memreq pulses; each cack routed to the correct client.
- Round-robin: client 2 re-requests immediately after every ack while clients 0 and 3 request once.
  - Required: order 2,3,0,2; never 2 twice in a row while others are pending.
- Write path: client 1 write, caddr=0x2004, cwdata=0x1234.
  - Required: memwr=1, memaddr=0x2004, memwdata=0x1234, all held stable until memack; cack=0010 after memack.
- Timeout: TMO=16, memack never returned for client 3.
  - Required: cack[3] and cerr[3] high 17 cycles after memreq; tmocnt=1.
  - Then a late memack in IDLE produces no cack, and the next pending client is issued normally.
- Reset mid-WAIT: assert rst two cycles after memreq.
  - Required: all outputs 0 immediately (async); after release, no cack for the dropped transaction; client 0 has priority.
